uc: RTL and testbench
=====================

# uc

Main control unit for the single-issue MIPS datapath, placed in the Instruction Decode stage. It decodes the 6-bit primary opcode of the fetched instruction into the datapath control signals: register destination select, ALU operand and operation class, branch, data-memory read/write, write-back select and register-file write enable. Outputs are registered, forming part of the ID/EX boundary.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high; the only clock is `clk`.
- Opcode  input  6  instruction bits [31:26].
- RegDst  output  1  1 = write register from rd (bits [15:11]); 0 = from rt (bits [20:16]).
- ALUOp  output  2  ALU operation class for the ALU-control block:
  - 00 = add.
  - 01 = subtract/compare.
  - 10 = use the funct field.
  - 11 = immediate logic/compare, decoded from the opcode.
- ALUSrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = rt.
- Branch  output  1  conditional branch (beq).
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- MemToReg  output  1  1 = write-back data from memory; 0 = from the ALU.
- RegWrite  output  1  register-file write enable.

## Operation
Decode, listed as RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
- R-type, 6'b000000: 1, 0, 0, 1, 0, 0, 0, 10.
- lw, 6'b100011: 0, 1, 1, 1, 1, 0, 0, 00.
- sw, 6'b101011: 0, 1, 0, 0, 0, 1, 0, 00.
- beq, 6'b000100: 0, 0, 0, 0, 0, 0, 1, 01.
- Immediate ALU opcodes (only when the macro below is defined):
  - addi, 6'b001000: 0, 1, 0, 1, 0, 0, 0, 00.
  - slti 6'b001010, andi 6'b001100, ori 6'b001101: 0, 1, 0, 1, 0, 0, 0, 11.
- Any other opcode: all outputs 0, i.e. a NOP. This never writes a register or memory.
- Don't-care fields are driven to 0, never X.
- MemRead and MemWrite are never both 1.
- RegWrite and MemWrite are never both 1.

## Timing
- All outputs are registered. `Opcode` is sampled at rising edge N, and its decode appears on the outputs after edge N and holds until edge N+1. Latency is 1 cycle.
- The unit decodes a new opcode every cycle. There is no handshake and no stall input.
- If `reset` is 1 at a rising edge, every output becomes 0 and ALUOp becomes 2'b00, regardless of `Opcode`.
- Reset has priority over decode. Asserting reset mid-stream squashes the opcode sampled at that edge.
- On the first edge after reset deasserts, the current `Opcode` is decoded normally.
- Outputs are undefined before the first reset edge. The bench must apply reset before checking outputs.

## Configuration
- `UC_IMM_ALU_EN` defined: addi, slti, andi and ori decode as listed under Operation.
- `UC_IMM_ALU_EN` undefined: those four opcodes fall into the "any other opcode" NOP row and give all-zero outputs.
- All other rows are identical in both builds.

## Structure
- Shared package `uc_pkg` holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI;
  - ALUOp localparams: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_IMM;
  - a packed struct `ctrl_t` carrying all eight fields, plus a constant `CTRL_NOP` = all-zero.
- One sub-module, `uc_decode`, is a purely combinational case on the opcode that produces `ctrl_t`.
- The top level `uc` only registers `ctrl_t`, applies the reset and unpacks it to the ports.

## Test plan
- Reset: drive reset=1 with Opcode=6'b100011 for one edge. Required response: all outputs 0, ALUOp=00.
- R-type then lw: after reset, Opcode=0 for one edge, then 6'b100011. Required response:
  - after the first edge: RegDst=1, RegWrite=1, ALUOp=10, all others 0;
  - after the second edge: ALUSrc=1, MemToReg=1, RegWrite=1, MemRead=1, ALUOp=00, all others 0.
- sw then beq back-to-back (6'b101011, then 6'b000100). Required response:
  - sw cycle: ALUSrc=1, MemWrite=1, all others 0;
  - beq cycle: Branch=1, ALUOp=01, all others 0;
  - each change appears exactly one cycle after the opcode changes.
- Illegal opcode 6'b111111, and 6'b001000 with `UC_IMM_ALU_EN` undefined. Required response: all outputs 0.
- With `UC_IMM_ALU_EN` defined:
  - addi gives ALUSrc=1, RegWrite=1, ALUOp=00;
  - ori (6'b001101) gives ALUSrc=1, RegWrite=1, ALUOp=11.
- Reset mid-stream: assert reset in the same cycle lw is presented. Required response: outputs 0 that cycle, and the next opcode decodes normally after reset deasserts.

Source files
------------

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - opcode, ALUOp and control-word definitions for the uc main control unit
package uc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/uc_if.sv
// rtl/uc_if.sv - opcode in / control signals out bundle between decode stage and uc
interface uc_if;

   logic [5:0] Opcode;
   logic       RegDst;
   logic [1:0] ALUOp;
   logic       ALUSrc;
   logic       Branch;
   logic       MemRead;
   logic       MemWrite;
   logic       MemToReg;
   logic       RegWrite;

   modport master (
      output Opcode,
      input  RegDst, ALUOp, ALUSrc, Branch, MemRead, MemWrite, MemToReg, RegWrite
   );

   modport slave (
      input  Opcode,
      output RegDst, ALUOp, ALUSrc, Branch, MemRead, MemWrite, MemToReg, RegWrite
   );

endinterface

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - combinational opcode decode; immediate ALU ops only with UC_IMM_ALU_EN
module uc_decode
   import uc_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = CTRL_NOP;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
         end
`ifdef UC_IMM_ALU_EN
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_SLTI, OP_ANDI, OP_ORI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_IMM;
         end
`endif
         // unknown opcodes stay a NOP so they can never write state
         default: ctrl = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/uc.sv
// rtl/uc.sv - MIPS main control unit, registered at ID/EX; UC_IMM_ALU_EN adds addi/slti/andi/ori
module uc
   import uc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   uc_if.slave  bus
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   uc_decode u_decode (
      .opcode (bus.Opcode),
      .ctrl   (ctrl_d)
   );

   // reset wins over decode, squashing the opcode sampled on that edge
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign bus.RegDst   = ctrl_q.reg_dst;
   assign bus.ALUSrc   = ctrl_q.alu_src;
   assign bus.MemToReg = ctrl_q.mem_to_reg;
   assign bus.RegWrite = ctrl_q.reg_write;
   assign bus.MemRead  = ctrl_q.mem_read;
   assign bus.MemWrite = ctrl_q.mem_write;
   assign bus.Branch   = ctrl_q.branch;
   assign bus.ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_uc.sv
// tb/tb_uc.sv - directed self-checking bench for uc; expectations follow UC_IMM_ALU_EN
module tb_uc;

   // {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
   localparam logic [8:0] E_ZERO  = 9'b0_0_0_0_0_0_0_00;
   localparam logic [8:0] E_RTYPE = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] E_LW    = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] E_SW    = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] E_BEQ   = 9'b0_0_0_0_0_0_1_01;
`ifdef UC_IMM_ALU_EN
   localparam logic [8:0] E_ADDI  = 9'b0_1_0_1_0_0_0_00;
   localparam logic [8:0] E_IMM   = 9'b0_1_0_1_0_0_0_11;
`else
   localparam logic [8:0] E_ADDI  = E_ZERO;
   localparam logic [8:0] E_IMM   = E_ZERO;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   uc_if bus ();

   uc dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.RegWrite,
              bus.MemRead, bus.MemWrite, bus.Branch, bus.ALUOp};
   endfunction

   task automatic tick(input logic rst, input logic [5:0] op);
      reset      = rst;
      bus.Opcode = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 6'b100011);
      checks++;
      if (obs() !== E_ZERO) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs(), E_ZERO);
      end
   endtask

   task automatic test_rtype_lw();
      tick(1'b0, 6'b000000);
      checks++;
      if (obs() !== E_RTYPE) begin
         errors++;
         $display("FAIL rtype_decode: got %b expected %b", obs(), E_RTYPE);
      end
      tick(1'b0, 6'b100011);
      checks++;
      if (obs() !== E_LW) begin
         errors++;
         $display("FAIL lw_decode: got %b expected %b", obs(), E_LW);
      end
   endtask

   task automatic test_back_to_back();
      // new opcode presented but no edge yet: previous lw decode must hold
      bus.Opcode = 6'b101011;
      #2;
      checks++;
      if (obs() !== E_LW) begin
         errors++;
         $display("FAIL sw_latency_hold: got %b expected %b", obs(), E_LW);
      end
      tick(1'b0, 6'b101011);
      checks++;
      if (obs() !== E_SW) begin
         errors++;
         $display("FAIL sw_decode: got %b expected %b", obs(), E_SW);
      end
      bus.Opcode = 6'b000100;
      #2;
      checks++;
      if (obs() !== E_SW) begin
         errors++;
         $display("FAIL beq_latency_hold: got %b expected %b", obs(), E_SW);
      end
      tick(1'b0, 6'b000100);
      checks++;
      if (obs() !== E_BEQ) begin
         errors++;
         $display("FAIL beq_decode: got %b expected %b", obs(), E_BEQ);
      end
   endtask

   task automatic test_illegal();
      tick(1'b0, 6'b111111);
      checks++;
      if (obs() !== E_ZERO) begin
         errors++;
         $display("FAIL illegal_111111: got %b expected %b", obs(), E_ZERO);
      end
   endtask

   task automatic test_imm();
      tick(1'b0, 6'b001000);
      checks++;
      if (obs() !== E_ADDI) begin
         errors++;
         $display("FAIL addi_decode: got %b expected %b", obs(), E_ADDI);
      end
      tick(1'b0, 6'b001101);
      checks++;
      if (obs() !== E_IMM) begin
         errors++;
         $display("FAIL ori_decode: got %b expected %b", obs(), E_IMM);
      end
      tick(1'b0, 6'b001010);
      checks++;
      if (obs() !== E_IMM) begin
         errors++;
         $display("FAIL slti_decode: got %b expected %b", obs(), E_IMM);
      end
      tick(1'b0, 6'b001100);
      checks++;
      if (obs() !== E_IMM) begin
         errors++;
         $display("FAIL andi_decode: got %b expected %b", obs(), E_IMM);
      end
   endtask

   task automatic test_reset_midstream();
      tick(1'b0, 6'b000000);
      checks++;
      if (obs() !== E_RTYPE) begin
         errors++;
         $display("FAIL mid_pre_rtype: got %b expected %b", obs(), E_RTYPE);
      end
      tick(1'b1, 6'b100011);
      checks++;
      if (obs() !== E_ZERO) begin
         errors++;
         $display("FAIL mid_reset_squash: got %b expected %b", obs(), E_ZERO);
      end
      tick(1'b0, 6'b100011);
      checks++;
      if (obs() !== E_LW) begin
         errors++;
         $display("FAIL mid_post_lw: got %b expected %b", obs(), E_LW);
      end
   endtask

   task automatic test_sweep();
      logic [8:0] exp_v;
      for (int i = 0; i < 64; i++) begin
         tick(1'b0, 6'(i));
         case (6'(i))
            6'b000000: exp_v = E_RTYPE;
            6'b100011: exp_v = E_LW;
            6'b101011: exp_v = E_SW;
            6'b000100: exp_v = E_BEQ;
            6'b001000: exp_v = E_ADDI;
            6'b001010, 6'b001100, 6'b001101: exp_v = E_IMM;
            default:   exp_v = E_ZERO;
         endcase
         checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL sweep_op_%0d: got %b expected %b", i, obs(), exp_v);
         end
         checks++;
         if ((bus.MemRead & bus.MemWrite) !== 1'b0 || (bus.RegWrite & bus.MemWrite) !== 1'b0) begin
            errors++;
            $display("FAIL sweep_exclusive_%0d: got %b expected no rd/wr or wb/wr overlap", i, obs());
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      bus.Opcode = 6'b000000;
      test_reset();
      test_rtype_lw();
      test_back_to_back();
      test_illegal();
      test_imm();
      test_reset_midstream();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
